// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with 2-bit counters
//
// Purpose: predicts direction and next PC for a fetch PC one cycle after the
// lookup, and trains its table from resolved branches.
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   lookup_valid, lookup_pc      fetch PC to predict
//   flush                        squash the prediction registered at this edge
//   update_valid, update_pc,
//   update_taken, update_target  resolved branch used for training
//   pred_valid, pred_taken,
//   pred_pc, pred_addr           registered prediction

module branch_predictor #(
    parameter int WordSize  = 32,
    parameter int IndexBits = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                lookup_valid,
    input  logic [WordSize-1:0] lookup_pc,
    input  logic                flush,
    input  logic                update_valid,
    input  logic [WordSize-1:0] update_pc,
    input  logic                update_taken,
    input  logic [WordSize-1:0] update_target,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_pc,
    output logic [WordSize-1:0] pred_addr
);

    localparam int Depth = 1 << IndexBits;
    localparam int TagW  = WordSize - IndexBits - 2;

    logic                valid_q  [Depth];
    logic                valid_d  [Depth];
    logic [TagW-1:0]     tag_q    [Depth];
    logic [TagW-1:0]     tag_d    [Depth];
    logic [WordSize-1:0] target_q [Depth];
    logic [WordSize-1:0] target_d [Depth];
    logic [1:0]          ctr_q    [Depth];
    logic [1:0]          ctr_d    [Depth];

    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [WordSize-1:0] pred_pc_q, pred_pc_d;
    logic [WordSize-1:0] pred_addr_q, pred_addr_d;

    logic [IndexBits-1:0] lk_idx, up_idx;
    logic [TagW-1:0]      lk_tag, up_tag;
    logic                 lk_hit, up_hit;

    // Byte offset within the instruction word never selects an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx = lookup_pc[IndexBits+1:2];
    assign lk_tag = lookup_pc[WordSize-1:IndexBits+2];
    assign up_idx = update_pc[IndexBits+1:2];
    assign up_tag = update_pc[WordSize-1:IndexBits+2];

    // Lookup reads the _q copy, so a same-cycle update is not visible until
    // the following cycle.
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_pc_d    = pred_pc_q;
        pred_addr_d  = pred_addr_q;
        if (flush) begin
            pred_taken_d = 1'b0;
        end else if (lookup_valid) begin
            pred_valid_d = 1'b1;
            pred_pc_d    = lookup_pc;
            if (lk_hit && ctr_q[lk_idx][1]) begin
                pred_taken_d = 1'b1;
                pred_addr_d  = target_q[lk_idx];
            end else begin
                pred_taken_d = 1'b0;
                pred_addr_d  = lookup_pc + WordSize'(4);
            end
        end
    end

    // Training is independent of flush.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    target_d[up_idx] = update_target;
                    if (ctr_q[up_idx] != 2'd3) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                end else if (ctr_q[up_idx] != 2'd0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = update_target;
                ctr_d[up_idx]    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Depth; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
            pred_addr_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
            pred_addr_q  <= pred_addr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_pc    = pred_pc_q;
    assign pred_addr  = pred_addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        flush;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] pred_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor #(.WordSize(32), .IndexBits(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .flush        (flush),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken),
        .update_target(update_target),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_pc      (pred_pc),
        .pred_addr    (pred_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lookup_valid  = 1'b0;
        lookup_pc     = '0;
        flush         = 1'b0;
        update_valid  = 1'b0;
        update_pc     = '0;
        update_taken  = 1'b0;
        update_target = '0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        idle();
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        step();
    endtask

    task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        idle();
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        step();
    endtask

    task automatic expect_pred(input string tag, input logic v, input logic tk,
                               input logic [31:0] pc, input logic [31:0] addr);
        check({tag, ".valid"}, 32'(pred_valid), 32'(v));
        check({tag, ".taken"}, 32'(pred_taken), 32'(tk));
        check({tag, ".pc"},    pred_pc,   pc);
        check({tag, ".addr"},  pred_addr, addr);
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        repeat (2) step();
        expect_pred("reset", 1'b0, 1'b0, 32'h0, 32'h0);
        rstn = 1'b1;

        lookup(32'h100);
        expect_pred("cold_miss", 1'b1, 1'b0, 32'h100, 32'h104);

        update(32'h100, 1'b1, 32'h200);
        check("idle.valid", 32'(pred_valid), 32'h0);
        check("idle.pc_hold", pred_pc, 32'h100);
        check("idle.addr_hold", pred_addr, 32'h104);

        lookup(32'h100);
        expect_pred("alloc_hit", 1'b1, 1'b1, 32'h100, 32'h200);

        update(32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b0, 32'h0);
        lookup(32'h100);
        expect_pred("ctr0", 1'b1, 1'b0, 32'h100, 32'h104);

        // Counter must stay 0: NT then T leaves it at 1, still not taken.
        update(32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        expect_pred("sat_low", 1'b1, 1'b0, 32'h100, 32'h104);
        update(32'h100, 1'b1, 32'h240);
        lookup(32'h100);
        expect_pred("retrain", 1'b1, 1'b1, 32'h100, 32'h240);

        update(32'h140, 1'b1, 32'h500);
        lookup(32'h100);
        expect_pred("alias_miss", 1'b1, 1'b0, 32'h100, 32'h104);
        lookup(32'h140);
        expect_pred("alias_hit", 1'b1, 1'b1, 32'h140, 32'h500);

        // Flush alongside a lookup and a not-taken update (counter 2->1).
        idle();
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        flush        = 1'b1;
        update_valid = 1'b1;
        update_pc    = 32'h140;
        update_taken = 1'b0;
        step();
        check("flush.valid", 32'(pred_valid), 32'h0);
        check("flush.taken", 32'(pred_taken), 32'h0);
        lookup(32'h140);
        expect_pred("flush_upd", 1'b1, 1'b0, 32'h140, 32'h144);

        lookup(32'hFFFF_FFFC);
        expect_pred("wrap", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);

        // Asynchronous reset in mid-cycle, with an update held across an edge.
        lookup(32'h100);
        idle();
        update_valid  = 1'b1;
        update_pc     = 32'h140;
        update_taken  = 1'b1;
        update_target = 32'h700;
        #2;
        rstn = 1'b0;
        #1;
        check("async.valid", 32'(pred_valid), 32'h0);
        check("async.pc", pred_pc, 32'h0);
        step();
        idle();
        step();
        rstn = 1'b1;

        lookup(32'h140);
        expect_pred("post_reset", 1'b1, 1'b0, 32'h140, 32'h144);

        idle();
        lookup_valid  = 1'b1;
        lookup_pc     = 32'h300;
        update_valid  = 1'b1;
        update_pc     = 32'h300;
        update_taken  = 1'b1;
        update_target = 32'h800;
        step();
        expect_pred("rbw", 1'b1, 1'b0, 32'h300, 32'h304);
        lookup(32'h300);
        expect_pred("rbw_next", 1'b1, 1'b1, 32'h300, 32'h800);

        idle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter WordSize, default 32, giving the address and PC width.
REQ-002 The module SHALL have parameter IndexBits, default 4, giving a table depth of 2^IndexBits entries.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rstn, input, 1; reset is asynchronous and active-low.
REQ-005 The module SHALL have port lookup_valid, input, 1, meaning fetch PC present this cycle.
REQ-006 The module SHALL have port lookup_pc, input, WordSize, meaning the fetch PC to predict.
REQ-007 The module SHALL have port flush, input, 1, meaning the current prediction was wrong and must be squashed.
REQ-008 The module SHALL have port update_valid, input, 1, meaning a resolved branch is present this cycle.
REQ-009 The module SHALL have port update_pc, input, WordSize, meaning the PC of the resolved branch.
REQ-010 The module SHALL have port update_taken, input, 1, meaning the actual branch outcome.
REQ-011 The module SHALL have port update_target, input, WordSize, meaning the actual taken target.
REQ-012 The module SHALL have port pred_valid, output, 1, meaning the pred_* outputs are meaningful.
REQ-013 The module SHALL have port pred_taken, output, 1, meaning the predicted direction.
REQ-014 The module SHALL have port pred_pc, output, WordSize, meaning the PC the prediction belongs to.
REQ-015 The module SHALL have port pred_addr, output, WordSize, meaning the predicted next PC.

Function
REQ-016 Table entry SHALL hold: valid bit; tag = pc[WordSize-1:IndexBits+2]; target (WordSize); 2-bit saturating counter.
REQ-017 Index SHALL be pc[IndexBits+1:2]; pc[1:0] SHALL be ignored.
REQ-018 Hit SHALL be defined as entry valid and stored tag equal to the PC tag.
REQ-019 Lookup SHALL have one-cycle latency: at each edge with lookup_valid=1 and flush=0, pred_valid<=1 and pred_pc<=lookup_pc.
REQ-020 On a hit with counter>=2, the module SHALL register pred_taken<=1 and pred_addr<=stored target.
REQ-021 Otherwise (miss, or counter<2) the module SHALL register pred_taken<=0 and pred_addr<=lookup_pc+4, truncated mod 2^WordSize (0xFFFFFFFC -> 0x00000000).
REQ-022 At an edge with lookup_valid=0, the module SHALL set pred_valid<=0 and hold pred_taken, pred_pc and pred_addr.
REQ-023 At an edge with flush=1, the module SHALL set pred_valid<=0 and pred_taken<=0 regardless of lookup_valid; the table is unaffected by flush.
REQ-024 Update on a hit SHALL: increment the counter if update_taken=1 (saturate at 3), else decrement it (saturate at 0); if update_taken=1, overwrite target with update_target.
REQ-025 Update on a miss with update_taken=1 SHALL allocate the entry: valid=1, tag, target=update_target, counter=2 (weakly taken), replacing any prior occupant.
REQ-026 Update on a miss with update_taken=0 SHALL leave the table unchanged.
REQ-027 A lookup and an update to the same index in the same cycle SHALL resolve read-before-write: the lookup uses the pre-update entry, and the update is applied at that edge.
REQ-028 An update and a flush in the same cycle SHALL both take effect; flush SHALL NOT suppress the update.
REQ-029 Table state SHALL change only through REQ-024 to REQ-026.

Reset
REQ-030 On rstn=0, immediately and independent of clk, the module SHALL clear all valid bits, set all counters to 1 (weakly not-taken), and set pred_valid=0, pred_taken=0, pred_pc=0, pred_addr=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending lookup or update; the first edge after rstn rises SHALL behave as an ordinary cycle.

Verification
REQ-032 Bench SHALL cover: after reset, lookup 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_pc=0x100, pred_addr=0x104.
REQ-033 Bench SHALL cover: update pc=0x100, taken, target=0x200; then lookup 0x100 -> pred_taken=1, pred_addr=0x200.
REQ-034 Bench SHALL cover: continuing from REQ-033, two not-taken updates to 0x100 (counter 2->1->0), then lookup -> pred_taken=0, pred_addr=0x104; a further not-taken update leaves the counter at 0.
REQ-035 Bench SHALL cover: a taken update to 0x140 (same index as 0x100 at IndexBits=4, different tag), then lookup 0x100 -> miss, pred_taken=0, pred_addr=0x104.
REQ-036 Bench SHALL cover: lookup 0x100 with flush=1 at the same edge -> pred_valid=0, pred_taken=0; and lookup 0xFFFFFFFC on a miss -> pred_addr=0x0.
REQ-037 Bench SHALL cover: a same-cycle lookup and taken update of 0x300 on an empty entry -> pred_taken=0 (read-before-write), then the next lookup of 0x300 -> pred_taken=1.
